// File: rtl/custom_axi_ip_sched.sv
// Round-robin scheduler sharing one custom_axi_ip engine
// between NUM_REQ requesters, with watchdog and error counter.
module custom_axi_ip_sched #(
  parameter  int NUM_REQ = 4,
  parameter  int TIMEOUT = 16,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [64*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  input  logic [NUM_REQ-1:0]      rsp_ready_i,
  output logic [63:0]             rsp_data_o,
  output logic                    rsp_err_o,
  output logic [63:0]             eng_data_o,
  output logic                    eng_enable_o,
  input  logic [63:0]             eng_data_i,
  input  logic                    eng_wen_i,
  input  logic [1:0]              eng_status_i,
  output logic                    busy_o,
  output logic [IDW-1:0]          grant_id_o,
  output logic [7:0]              err_count_o
);

  localparam int TW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_e;

  state_e               state_q;
  logic [IDW-1:0]       grant_q;
  logic [IDW-1:0]       last_q;
  logic [TW-1:0]        timer_q;
  logic [63:0]          op_q;
  logic [63:0]          eng_data_q;
  logic [63:0]          rsp_data_q;
  logic                 rsp_err_q;
  logic [7:0]           err_cnt_q;

  logic                 gnt_vld;
  logic [IDW-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]   gnt_oh;
  logic [NUM_REQ-1:0]   rsp_oh;
  int                   k;

  // Round-robin pick: first valid requester after the last one served.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    gnt_oh  = '0;
    k       = 0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(last_q) + i) % NUM_REQ;
      if (!gnt_vld && req_valid_i[k]) begin
        gnt_vld   = 1'b1;
        gnt_idx   = IDW'(k);
        gnt_oh    = '0;
        gnt_oh[k] = 1'b1;
      end
    end
  end

  // Response valid goes only to the requester that owns the job.
  always_comb begin
    rsp_oh = '0;
    if (state_q == RESP) rsp_oh[grant_q] = 1'b1;
  end

  // Job sequencing: accept, start engine, wait/watchdog, respond.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= IDW'(NUM_REQ - 1);
      timer_q    <= '0;
      op_q       <= '0;
      eng_data_q <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            op_q    <= req_data_i[int'(gnt_idx)*64 +: 64];
            grant_q <= gnt_idx;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          eng_data_q <= op_q;
          timer_q    <= '0;
          state_q    <= WAIT;
        end
        WAIT: begin
          if (eng_wen_i) begin
            rsp_data_q <= eng_data_i;
            rsp_err_q  <= 1'b0;
            state_q    <= RESP;
          end else if (eng_status_i == 2'd3) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state_q    <= RESP;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b1;
            state_q    <= RESP;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        RESP: begin
          if (rsp_ready_i[grant_q]) begin
            last_q  <= grant_q;
            state_q <= IDLE;
            if (rsp_err_q && err_cnt_q != 8'hFF)
              err_cnt_q <= err_cnt_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Ready is suppressed during reset so nothing is accepted then.
  assign req_ready_o  = (state_q == IDLE && rst_ni) ? gnt_oh : '0;
  assign rsp_valid_o  = rsp_oh;
  assign rsp_data_o   = rsp_data_q;
  assign rsp_err_o    = rsp_err_q;
  assign eng_enable_o = (state_q == ISSUE);
  assign eng_data_o   = (state_q == ISSUE) ? op_q : eng_data_q;
  assign busy_o       = (state_q != IDLE);
  assign grant_id_o   = grant_q;
  assign err_count_o  = err_cnt_q;

endmodule

// File: tb/tb_custom_axi_ip_sched.sv
// Directed bench for custom_axi_ip_sched with a small
// behavioural engine model (nominal, hang, error modes).
module tb_custom_axi_ip_sched;

  localparam int N = 4;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [64*N-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [N-1:0]    rsp_ready;
  logic [63:0]     rsp_data;
  logic            rsp_err;
  logic [63:0]     eng_data_o;
  logic            eng_en;
  logic [63:0]     eng_data_i;
  logic            eng_wen;
  logic [1:0]      eng_status;
  logic            busy;
  logic [1:0]      grant_id;
  logic [7:0]      err_count;

  int errors = 0;
  int checks = 0;
  int mode   = 0;
  int ecnt;

  custom_axi_ip_sched #(.NUM_REQ(N), .TIMEOUT(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_data_i   (req_data),
    .req_ready_o  (req_ready),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_data_o   (rsp_data),
    .rsp_err_o    (rsp_err),
    .eng_data_o   (eng_data_o),
    .eng_enable_o (eng_en),
    .eng_data_i   (eng_data_i),
    .eng_wen_i    (eng_wen),
    .eng_status_i (eng_status),
    .busy_o       (busy),
    .grant_id_o   (grant_id),
    .err_count_o  (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model: ecnt counts cycles since the enable cycle.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else if (eng_en) ecnt <= 1;
    else if (ecnt != 0 && ecnt < 200) ecnt <= ecnt + 1;
  end

  assign eng_wen    = (mode == 0) && (ecnt == 3);
  assign eng_data_i = eng_wen ?
    {eng_data_o[31:0] + 32'd1, eng_data_o[31:0] + 32'd1} : 64'd0;
  assign eng_status = (ecnt == 0) ? 2'd0 :
                      (mode == 2 && ecnt == 2) ? 2'd3 :
                      (mode == 0 && ecnt >= 3) ? 2'd2 : 2'd1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_rsp(output int n, output int ens);
    n   = 1;
    ens = eng_en ? 1 : 0;
    while (rsp_valid == '0 && n < 60) begin
      tick();
      n++;
      if (eng_en) ens++;
    end
  endtask

  function automatic logic [63:0] nom(input logic [63:0] op);
    return {op[31:0] + 32'd1, op[31:0] + 32'd1};
  endfunction

  // One full job for requester g, called while the DUT is in IDLE.
  task automatic do_job(input int g, input logic [63:0] op,
                        input logic ee, input logic [63:0] ed,
                        input int lat);
    int n;
    int ens;
    chk("req_ready", req_ready, 64'(1 << g));
    tick();
    chk("eng_en", eng_en, 1);
    chk("eng_data", eng_data_o, op);
    wait_rsp(n, ens);
    chk("latency", n, lat);
    chk("en_pulses", ens, 1);
    chk("rsp_valid", rsp_valid, 64'(1 << g));
    chk("grant_id", grant_id, g);
    chk("rsp_err", rsp_err, ee);
    chk("rsp_data", rsp_data, ed);
    rsp_ready = '1;
    tick();
    rsp_ready = '0;
    chk("busy_after", busy, 0);
  endtask

  initial begin
    logic [63:0] hold;
    rst_n     = 1'b0;
    req_valid = '1;
    req_data  = '0;
    rsp_ready = '0;
    for (int k = 0; k < N; k++) req_data[64*k +: 64] = 64'h100 + k;
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_eng_en", eng_en, 0);
    chk("rst_eng_data", eng_data_o, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_errcnt", err_count, 0);
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    // Single nominal job
    mode = 0;
    req_data[63:0] = 64'h5;
    req_valid = 4'b0001;
    #1;
    do_job(0, 64'h5, 1'b0, 64'h0000_0006_0000_0006, 5);
    req_valid = '0;
    chk("single_errcnt", err_count, 0);
    req_data[63:0] = 64'h100;

    // Fairness from a fresh reset: 0,1,2,3,0,1,2,3
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    #1;
    for (int j = 0; j < 8; j++)
      do_job(j % 4, 64'h100 + (j % 4), 1'b0,
             nom(64'h100 + (j % 4)), 5);
    req_valid = '0;

    // Watchdog timeout: 1 ISSUE + 16 WAIT + RESP
    mode = 1;
    req_valid = 4'b0001;
    #1;
    do_job(0, 64'h100, 1'b1, 64'd0, 18);
    req_valid = '0;
    chk("timeout_errcnt", err_count, 1);

    // Engine error in second WAIT cycle, then saturation
    mode = 2;
    req_valid = 4'b0010;
    #1;
    do_job(1, 64'h101, 1'b1, 64'd0, 4);
    chk("err_errcnt", err_count, 2);
    for (int j = 0; j < 299; j++) do_job(1, 64'h101, 1'b1, 64'd0, 4);
    chk("err_saturate", err_count, 255);
    req_valid = '0;

    // Backpressure on requester 2
    mode = 0;
    req_valid = 4'b0101;
    #1;
    chk("bp_ready", req_ready, 4'b0100);
    tick();
    begin
      int n;
      int ens;
      wait_rsp(n, ens);
      chk("bp_latency", n, 5);
    end
    hold = rsp_data;
    chk("bp_data", hold, nom(64'h102));
    rsp_ready = 4'b1011;
    for (int j = 0; j < 10; j++) begin
      tick();
      chk("bp_valid_hold", rsp_valid, 4'b0100);
      chk("bp_data_hold", rsp_data, hold);
      chk("bp_ready_hold", req_ready, 0);
    end
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    chk("bp_next_grant", req_ready, 4'b0001);

    // Reset in the middle of a job
    mode = 1;
    tick();
    tick();
    chk("mid_busy", busy, 1);
    chk("mid_grant", grant_id, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_grant", grant_id, 0);
    chk("mid_rst_errcnt", err_count, 0);
    chk("mid_rst_eng_data", eng_data_o, 0);
    chk("mid_rst_ready", req_ready, 0);
    req_valid = 4'b0100;
    tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_skip0", req_ready, 4'b0100);
    chk("post_rst_rsp", rsp_valid, 0);
    req_valid = 4'b0101;
    #1;
    chk("post_rst_prio0", req_ready, 4'b0001);
    req_valid = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
